// File: rtl/uart_tx_fifo_drain.sv
// UART transmit drain: pops bytes from a show-ahead FIFO and sends them as
// 8N1-style frames (start, DBIT data bits LSB first, SB_TICK/16 stop bits),
// timed by an internal 16x oversampling baud divider.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO head word, valid while fifo_empty=0
//   fifo_rd      pop strobe, decoded from IDLE and fifo_empty (same cycle)
//   tx           serial line, idle high, registered
//   tx_busy      high while a frame is on the line, registered
//   tx_done_tick one-cycle pulse in the last cycle of each stop bit
module uart_tx_fifo_drain #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned DVSR    = 326,
    parameter int unsigned DVSR_W  = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int unsigned S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int unsigned S_W   = $clog2(S_MAX);
    localparam int unsigned N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [DVSR_W-1:0] div;
    logic [S_W-1:0]    s;
    logic [N_W-1:0]    n;
    logic [DBIT-1:0]   b;
    logic              s_tick;

    assign s_tick = (div == DVSR_W'(DVSR - 1));

    // Pop is gated by reset so the FIFO never loses a byte while we are held.
    assign fifo_rd      = (state == IDLE) && !fifo_empty && !reset;
    assign tx_done_tick = (state == STOP) && s_tick && (s == S_W'(SB_TICK - 1));

    // Divider held at zero in IDLE so each frame's bit grid starts at its start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (state == IDLE || s_tick) begin
            div <= '0;
        end else begin
            div <= div + DVSR_W'(1);
        end
    end

    // Frame FSM; tx and tx_busy are loaded together with the state so the
    // line changes in the same cycle the state does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            b       <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        b       <= fifo_data;
                        s       <= '0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_W'(15)) begin
                            s     <= '0;
                            n     <= '0;
                            tx    <= b[0];
                            state <= DATA;
                        end else begin
                            s <= s + S_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_W'(15)) begin
                            s <= '0;
                            b <= {1'b0, b[DBIT-1:1]};
                            if (n == N_W'(DBIT - 1)) begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end else begin
                                n  <= n + N_W'(1);
                                tx <= b[1];
                            end
                        end else begin
                            s <= s + S_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == S_W'(SB_TICK - 1)) begin
                            s       <= '0;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            s <= s + S_W'(1);
                        end
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
